// File: rtl/rcu_pkg.sv
// Shared definitions for the RISC multi-cycle control unit: opcodes, bus mux sources,
// ALU operations and the controller state encoding.
package rcu_pkg;

    localparam logic [3:0] OpNop  = 4'h0;
    localparam logic [3:0] OpAdd  = 4'h1;
    localparam logic [3:0] OpSub  = 4'h2;
    localparam logic [3:0] OpAnd  = 4'h3;
    localparam logic [3:0] OpOr   = 4'h4;
    localparam logic [3:0] OpLdi  = 4'h5;
    localparam logic [3:0] OpLd   = 4'h6;
    localparam logic [3:0] OpSt   = 4'h7;
    localparam logic [3:0] OpBeqz = 4'h8;
    localparam logic [3:0] OpJmp  = 4'h9;
    localparam logic [3:0] OpHalt = 4'hF;

    localparam logic [2:0] BusRfA  = 3'd0;
    localparam logic [2:0] BusRfB  = 3'd1;
    localparam logic [2:0] BusAlu  = 3'd2;
    localparam logic [2:0] BusMdr  = 3'd3;
    localparam logic [2:0] BusPc   = 3'd4;
    localparam logic [2:0] BusSext = 3'd5;
    localparam logic [2:0] BusZext = 3'd6;
    localparam logic [2:0] BusZero = 3'd7;

    localparam logic [1:0] AluAdd = 2'b00;
    localparam logic [1:0] AluSub = 2'b01;
    localparam logic [1:0] AluAnd = 2'b10;
    localparam logic [1:0] AluOr  = 2'b11;

    typedef enum logic [2:0] {
        StFetch,
        StDecode,
        StExec,
        StMem,
        StWb,
        StHalt
    } state_e;

    function automatic logic [1:0] alu_op_of(input logic [3:0] op);
        case (op)
            OpSub:   return AluSub;
            OpAnd:   return AluAnd;
            OpOr:    return AluOr;
            default: return AluAdd;
        endcase
    endfunction

endpackage

// File: rtl/rcu_decode.sv
// Combinational opcode classifier; exactly one class output is high for any opcode.
module rcu_decode
    import rcu_pkg::*;
#(
    parameter int unsigned OPW = 4
) (
    input  logic [OPW-1:0] op,
    output logic           is_nop,
    output logic           is_alu,
    output logic           is_ldi,
    output logic           is_ld,
    output logic           is_st,
    output logic           is_br,
    output logic           is_jmp,
    output logic           is_halt,
    output logic           is_illegal
);

    always_comb begin
        is_nop     = 1'b0;
        is_alu     = 1'b0;
        is_ldi     = 1'b0;
        is_ld      = 1'b0;
        is_st      = 1'b0;
        is_br      = 1'b0;
        is_jmp     = 1'b0;
        is_halt    = 1'b0;
        is_illegal = 1'b0;
        case (op)
            OpNop:                     is_nop     = 1'b1;
            OpAdd, OpSub, OpAnd, OpOr: is_alu     = 1'b1;
            OpLdi:                     is_ldi     = 1'b1;
            OpLd:                      is_ld      = 1'b1;
            OpSt:                      is_st      = 1'b1;
            OpBeqz:                    is_br      = 1'b1;
            OpJmp:                     is_jmp     = 1'b1;
            OpHalt:                    is_halt    = 1'b1;
            default:                   is_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/rcu_multicycle_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer driving the datapath bus mux select
// and all datapath load/write enables.
module rcu_multicycle_ctrl
    import rcu_pkg::*;
#(
    parameter int unsigned OPW = 4
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [15:0] instr,
    input  logic        zero_flag,
    input  logic        mem_ready,
    output logic [2:0]  bus_sel,
    output logic        ir_load,
    output logic        pc_inc,
    output logic        pc_load,
    output logic        rf_we,
    output logic        mdr_load,
    output logic [1:0]  alu_op,
    output logic        mem_req,
    output logic        mem_we,
    output logic        halted,
    output logic        illegal
);

    state_e state_q, state_d;
    logic   illegal_q, illegal_d;

    logic [OPW-1:0] op;
    logic           is_nop, is_alu, is_ldi, is_ld, is_st, is_br, is_jmp, is_halt, is_illegal;
    logic           unused_instr;

    assign op           = instr[15 -: OPW];
    assign unused_instr = ^instr[15-OPW:0];

    rcu_decode #(
        .OPW (OPW)
    ) u_decode (
        .op         (op),
        .is_nop     (is_nop),
        .is_alu     (is_alu),
        .is_ldi     (is_ldi),
        .is_ld      (is_ld),
        .is_st      (is_st),
        .is_br      (is_br),
        .is_jmp     (is_jmp),
        .is_halt    (is_halt),
        .is_illegal (is_illegal)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= StFetch;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
        end
    end

    assign illegal_d = illegal_q | ((state_q == StDecode) && is_illegal);
    assign illegal   = illegal_q;
    assign halted    = (state_q == StHalt);

    always_comb begin
        state_d  = state_q;
        bus_sel  = BusRfA;
        ir_load  = 1'b0;
        pc_inc   = 1'b0;
        pc_load  = 1'b0;
        rf_we    = 1'b0;
        mdr_load = 1'b0;
        alu_op   = AluAdd;
        mem_req  = 1'b0;
        mem_we   = 1'b0;

        unique case (state_q)
            StFetch: begin
                bus_sel = BusPc;
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_load = 1'b1;
                    pc_inc  = 1'b1;
                    state_d = StDecode;
                end
            end
            StDecode: begin
                if (is_nop) begin
                    state_d = StFetch;
                end else if (is_halt || is_illegal) begin
                    state_d = StHalt;
                end else begin
                    state_d = StExec;
                end
            end
            StExec: begin
                state_d = StFetch;
                if (is_alu) begin
                    alu_op  = alu_op_of(op);
                    bus_sel = BusAlu;
                    state_d = StWb;
                end else if (is_ldi) begin
                    bus_sel = BusSext;
                    state_d = StWb;
                end else if (is_ld || is_st) begin
                    mem_req = 1'b1;
                    mem_we  = is_st;
                    state_d = StMem;
                end else if (is_br) begin
                    // Taken branch: ALU forms PC + sext(imm6) and PC loads from the bus.
                    if (zero_flag) begin
                        pc_load = 1'b1;
                        bus_sel = BusAlu;
                    end
                end else if (is_jmp) begin
                    pc_load = 1'b1;
                end
            end
            StMem: begin
                mem_req = 1'b1;
                mem_we  = is_st;
                if (mem_ready) begin
                    mdr_load = is_ld;
                    state_d  = is_ld ? StWb : StFetch;
                end
            end
            StWb: begin
                rf_we   = 1'b1;
                state_d = StFetch;
                if (is_ld) begin
                    bus_sel = BusMdr;
                end else if (is_ldi) begin
                    bus_sel = BusSext;
                end else begin
                    bus_sel = BusAlu;
                    alu_op  = alu_op_of(op);
                end
            end
            StHalt: begin
            end
            default: state_d = StFetch;
        endcase

        // Reset parks the FSM in FETCH; keep the memory request and fetch enables quiet
        // until reset is released.
        if (!RST_N) begin
            mem_req = 1'b0;
            ir_load = 1'b0;
            pc_inc  = 1'b0;
        end
    end

endmodule

// File: tb/tb_rcu_multicycle_ctrl.sv
// Directed self-checking bench for rcu_multicycle_ctrl; output vector per cycle is
// {bus_sel, ir_load, pc_inc, pc_load, rf_we, mdr_load, alu_op, mem_req, mem_we, halted, illegal}.
module tb_rcu_multicycle_ctrl;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic [15:0] instr = 16'h0000;
    logic        zero_flag = 1'b0;
    logic        mem_ready = 1'b0;
    logic [2:0]  bus_sel;
    logic        ir_load, pc_inc, pc_load, rf_we, mdr_load;
    logic [1:0]  alu_op;
    logic        mem_req, mem_we, halted, illegal;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [13:0] VReset  = 14'b100_00000_00_0000;
    localparam logic [13:0] VFetchW = 14'b100_00000_00_1000;
    localparam logic [13:0] VFetchR = 14'b100_11000_00_1000;
    localparam logic [13:0] VDecode = 14'b000_00000_00_0000;

    always #5 CLK = ~CLK;

    rcu_multicycle_ctrl #(
        .OPW (4)
    ) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .instr     (instr),
        .zero_flag (zero_flag),
        .mem_ready (mem_ready),
        .bus_sel   (bus_sel),
        .ir_load   (ir_load),
        .pc_inc    (pc_inc),
        .pc_load   (pc_load),
        .rf_we     (rf_we),
        .mdr_load  (mdr_load),
        .alu_op    (alu_op),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .halted    (halted),
        .illegal   (illegal)
    );

    function automatic logic [13:0] outs();
        return {bus_sel, ir_load, pc_inc, pc_load, rf_we, mdr_load, alu_op,
                mem_req, mem_we, halted, illegal};
    endfunction

    // All tasks start and end on a falling edge with the DUT in FETCH.
    task automatic test_reset();
        mem_ready = 1'b1;
        repeat (2) @(negedge CLK);
        #1;
        n_checks++;
        if (outs() !== VReset) begin
            n_fail++;
            $display("FAIL reset_hold: got %b expected %b", outs(), VReset);
        end
        @(negedge CLK);
        mem_ready = 1'b0;
        RST_N     = 1'b1;
        #1;
        n_checks++;
        if (outs() !== VFetchW) begin
            n_fail++;
            $display("FAIL reset_release: got %b expected %b", outs(), VFetchW);
        end
        @(negedge CLK);
    endtask

    task automatic test_alu();
        logic [3:0]  ops  [4] = '{4'h1, 4'h2, 4'h3, 4'h4};
        logic [1:0]  alus [4] = '{2'b00, 2'b01, 2'b10, 2'b11};
        logic [13:0] exp  [5];
        logic        mr   [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        for (int k = 0; k < 4; k++) begin
            instr  = {ops[k], 12'h298};
            exp[0] = VFetchR;
            exp[1] = VDecode;
            exp[2] = {3'd2, 5'b00000, alus[k], 4'b0000};
            exp[3] = {3'd2, 5'b00010, alus[k], 4'b0000};
            exp[4] = VFetchW;
            for (int i = 0; i < 5; i++) begin
                mem_ready = mr[i];
                #1;
                n_checks++;
                if (outs() !== exp[i]) begin
                    n_fail++;
                    $display("FAIL alu op=%0h cycle %0d: got %b expected %b",
                             ops[k], i + 1, outs(), exp[i]);
                end
                @(negedge CLK);
            end
        end
    endtask

    task automatic test_ldi();
        logic [13:0] exp [5] = '{VFetchR, VDecode, 14'b101_00000_00_0000,
                                 14'b101_00010_00_0000, VFetchW};
        logic        mr  [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        instr = 16'h52BF;
        for (int i = 0; i < 5; i++) begin
            mem_ready = mr[i];
            #1;
            n_checks++;
            if (outs() !== exp[i]) begin
                n_fail++;
                $display("FAIL ldi cycle %0d: got %b expected %b", i + 1, outs(), exp[i]);
            end
            @(negedge CLK);
        end
    endtask

    task automatic test_ld_wait();
        logic [13:0] exp [8] = '{VFetchR, VDecode, 14'b000_00000_00_1000,
                                 14'b000_00000_00_1000, 14'b000_00000_00_1000,
                                 14'b000_00001_00_1000, 14'b011_00010_00_0000, VFetchW};
        logic        mr  [8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        instr = 16'h6280;
        for (int i = 0; i < 8; i++) begin
            mem_ready = mr[i];
            #1;
            n_checks++;
            if (outs() !== exp[i]) begin
                n_fail++;
                $display("FAIL ld_wait cycle %0d: got %b expected %b", i + 1, outs(), exp[i]);
            end
            @(negedge CLK);
        end
    endtask

    task automatic test_st();
        logic [13:0] exp [5] = '{VFetchR, VDecode, 14'b000_00000_00_1100,
                                 14'b000_00000_00_1100, VFetchW};
        logic        mr  [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        instr = 16'h7280;
        for (int i = 0; i < 5; i++) begin
            mem_ready = mr[i];
            #1;
            n_checks++;
            if (outs() !== exp[i]) begin
                n_fail++;
                $display("FAIL st cycle %0d: got %b expected %b", i + 1, outs(), exp[i]);
            end
            @(negedge CLK);
        end
    endtask

    task automatic test_beqz();
        logic [13:0] exec_v [2] = '{14'b010_00100_00_0000, 14'b000_00000_00_0000};
        logic        zf     [2] = '{1'b1, 1'b0};
        logic [13:0] exp    [4];
        instr = 16'h803F;
        for (int k = 0; k < 2; k++) begin
            zero_flag = zf[k];
            exp = '{VFetchR, VDecode, exec_v[k], VFetchW};
            for (int i = 0; i < 4; i++) begin
                mem_ready = (i < 3);
                #1;
                n_checks++;
                if (outs() !== exp[i]) begin
                    n_fail++;
                    $display("FAIL beqz zf=%0b cycle %0d: got %b expected %b",
                             zf[k], i + 1, outs(), exp[i]);
                end
                @(negedge CLK);
            end
        end
        zero_flag = 1'b0;
    endtask

    task automatic test_jmp_nop();
        logic [13:0] exp [6] = '{VFetchR, VDecode, 14'b000_00100_00_0000,
                                 VFetchR, VDecode, VFetchW};
        logic [15:0] ins [6] = '{16'h9080, 16'h9080, 16'h9080, 16'h0000, 16'h0000, 16'h0000};
        logic        mr  [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 6; i++) begin
            instr     = ins[i];
            mem_ready = mr[i];
            #1;
            n_checks++;
            if (outs() !== exp[i]) begin
                n_fail++;
                $display("FAIL jmp_nop cycle %0d: got %b expected %b", i + 1, outs(), exp[i]);
            end
            @(negedge CLK);
        end
    endtask

    task automatic test_reset_mid_mem();
        logic [13:0] exp [4] = '{VFetchR, VDecode, 14'b000_00000_00_1000,
                                 14'b000_00000_00_1000};
        logic        mr  [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
        instr = 16'h6280;
        for (int i = 0; i < 4; i++) begin
            mem_ready = mr[i];
            #1;
            n_checks++;
            if (outs() !== exp[i]) begin
                n_fail++;
                $display("FAIL rst_mem cycle %0d: got %b expected %b", i + 1, outs(), exp[i]);
            end
            @(negedge CLK);
        end
        // Now in MEM still waiting; reset asynchronously mid-cycle.
        #2;
        RST_N = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (outs() !== VReset) begin
                n_fail++;
                $display("FAIL rst_mem_held %0d: got %b expected %b", i, outs(), VReset);
            end
            @(negedge CLK);
            #1;
        end
        instr     = 16'h0000;
        mem_ready = 1'b1;
        RST_N     = 1'b1;
        #1;
        n_checks++;
        if (outs() !== VFetchR) begin
            n_fail++;
            $display("FAIL rst_mem_release: got %b expected %b", outs(), VFetchR);
        end
        @(negedge CLK);
        mem_ready = 1'b0;
        #1;
        n_checks++;
        if (outs() !== VDecode) begin
            n_fail++;
            $display("FAIL rst_mem_nop_decode: got %b expected %b", outs(), VDecode);
        end
        @(negedge CLK);
        #1;
        n_checks++;
        if (outs() !== VFetchW) begin
            n_fail++;
            $display("FAIL rst_mem_refetch: got %b expected %b", outs(), VFetchW);
        end
        @(negedge CLK);
    endtask

    task automatic test_illegal();
        instr     = 16'hB000;
        mem_ready = 1'b1;
        #1;
        n_checks++;
        if (outs() !== VFetchR) begin
            n_fail++;
            $display("FAIL illegal_fetch: got %b expected %b", outs(), VFetchR);
        end
        @(negedge CLK);
        #1;
        n_checks++;
        if (outs() !== VDecode) begin
            n_fail++;
            $display("FAIL illegal_decode: got %b expected %b", outs(), VDecode);
        end
        @(negedge CLK);
        for (int i = 0; i < 20; i++) begin
            mem_ready = i[0];
            #1;
            n_checks++;
            if (outs() !== 14'b000_00000_00_0011) begin
                n_fail++;
                $display("FAIL illegal_sticky cycle %0d: got %b expected %b",
                         i, outs(), 14'b000_00000_00_0011);
            end
            @(negedge CLK);
        end
        RST_N = 1'b0;
        #1;
        n_checks++;
        if (outs() !== VReset) begin
            n_fail++;
            $display("FAIL illegal_clear: got %b expected %b", outs(), VReset);
        end
        @(negedge CLK);
        instr     = 16'h0000;
        mem_ready = 1'b0;
        RST_N     = 1'b1;
        #1;
        n_checks++;
        if (outs() !== VFetchW) begin
            n_fail++;
            $display("FAIL illegal_restart: got %b expected %b", outs(), VFetchW);
        end
        @(negedge CLK);
    endtask

    task automatic test_halt();
        instr     = 16'hF000;
        mem_ready = 1'b1;
        #1;
        n_checks++;
        if (outs() !== VFetchR) begin
            n_fail++;
            $display("FAIL halt_fetch: got %b expected %b", outs(), VFetchR);
        end
        @(negedge CLK);
        #1;
        n_checks++;
        if (outs() !== VDecode) begin
            n_fail++;
            $display("FAIL halt_decode: got %b expected %b", outs(), VDecode);
        end
        @(negedge CLK);
        for (int i = 0; i < 10; i++) begin
            mem_ready = ~i[0];
            zero_flag = i[1];
            #1;
            n_checks++;
            if (outs() !== 14'b000_00000_00_0010) begin
                n_fail++;
                $display("FAIL halt_hold cycle %0d: got %b expected %b",
                         i, outs(), 14'b000_00000_00_0010);
            end
            @(negedge CLK);
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_ldi();
        test_ld_wait();
        test_st();
        test_beqz();
        test_jmp_nop();
        test_reset_mid_mem();
        test_illegal();
        test_halt();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
